frame_sequencer: RTL

Sequences one rendering frame after the AXI-lite register target pulses frame_start. Latches the base addresses and triangle count, then issues one fetch request per triangle to the vertex/colour fetch unit over a valid/ready channel. Bounds the number of in-flight triangles, tracks their completions and raises an end-of-frame interrupt. Produces the global_state word that the register target returns on reads at address 0x0.

---
 rtl/frame_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer
// Runs one rendering frame after a frame_start pulse from the register target.
// It latches the base addresses and the triangle count, then issues one fetch
// request per triangle over a valid/ready channel. It limits the number of
// issued-but-not-completed triangles, counts completions, and raises an
// end-of-frame interrupt. It also builds the global_state status word.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   frame_start        single-cycle start pulse (accepted only in IDLE)
//   interrupt_ack      single-cycle irq acknowledge (accepted only in DONE)
//   triangles_count    triangles in the frame
//   base_addr_vertex   first vertex address
//   base_addr_color    first colour address
//   req_valid/ready    fetch request handshake
//   req_vertex_addr    vertex address of the current triangle
//   req_color_addr     colour address of the current triangle
//   req_index          0-based triangle index
//   done_valid         one pulse per completed triangle
//   irq                end-of-frame interrupt (level, high in DONE)
//   global_state       {completed[23:0], 2'b0, state, spurious, overrun, irq, busy}
//   frame_cycles       ISSUE+DRAIN cycle counter
//
// Optional build macro: FRAME_SEQUENCER_PERF_EN
//   When defined, frame_cycles is a saturating performance counter.
//   When undefined, frame_cycles is tied to 0.

module frame_sequencer #(
   parameter int MADDR_WIDTH     = 32,
   parameter int VERTEX_STRIDE   = 36,
   parameter int COLOR_STRIDE    = 12,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_start,
   input  logic                   interrupt_ack,
   input  logic [31:0]            triangles_count,
   input  logic [MADDR_WIDTH-1:0] base_addr_vertex,
   input  logic [MADDR_WIDTH-1:0] base_addr_color,
   output logic                   req_valid,
   input  logic                   req_ready,
   output logic [MADDR_WIDTH-1:0] req_vertex_addr,
   output logic [MADDR_WIDTH-1:0] req_color_addr,
   output logic [31:0]            req_index,
   input  logic                   done_valid,
   output logic                   irq,
   output logic [31:0]            global_state,
   output logic [31:0]            frame_cycles
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0]             MAX_OUT = 4'(MAX_OUTSTANDING);
   localparam logic [MADDR_WIDTH-1:0] VSTEP   = MADDR_WIDTH'(VERTEX_STRIDE);
   localparam logic [MADDR_WIDTH-1:0] CSTEP   = MADDR_WIDTH'(COLOR_STRIDE);

   state_t                 state_q, state_d;
   logic [MADDR_WIDTH-1:0] vtx_q, col_q;
   logic [31:0]            idx_q, count_q;
   logic [3:0]             outst_q;
   logic [23:0]            completed_q;
   logic                   overrun_q, spurious_q;
   logic                   busy;

   logic start_acc, hs, last_hs, done_acc, spurious_evt;

   assign start_acc    = frame_start && (state_q == S_IDLE);
   assign hs           = req_valid && req_ready;
   assign last_hs      = hs && (idx_q == count_q - 32'd1);
   assign done_acc     = done_valid && (outst_q != 4'd0);
   assign spurious_evt = done_valid && (outst_q == 4'd0);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (frame_start) state_d = (triangles_count == 32'd0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (last_hs) state_d = S_DRAIN;
         S_DRAIN: if (outst_q == 4'd0) state_d = S_DONE;
         S_DONE:  if (interrupt_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: depends only on registered state, never on req_ready
   always_comb begin
      req_valid = 1'b0;
      irq       = 1'b0;
      busy      = 1'b0;
      case (state_q)
         S_ISSUE: begin
            busy      = 1'b1;
            req_valid = (outst_q < MAX_OUT);
         end
         S_DRAIN: busy = 1'b1;
         S_DONE:  irq  = 1'b1;
         default: ;
      endcase
   end

   // Frame registers, in-flight tracking and error flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vtx_q       <= '0;
         col_q       <= '0;
         idx_q       <= '0;
         count_q     <= '0;
         outst_q     <= '0;
         completed_q <= '0;
         overrun_q   <= 1'b0;
         spurious_q  <= 1'b0;
      end else begin
         if (start_acc) begin
            vtx_q   <= base_addr_vertex;
            col_q   <= base_addr_color;
            count_q <= triangles_count;
            idx_q   <= '0;
         end else if (hs) begin
            vtx_q <= vtx_q + VSTEP;
            col_q <= col_q + CSTEP;
            idx_q <= idx_q + 32'd1;
         end

         if (start_acc) outst_q <= '0;
         else begin
            case ({hs, done_acc})
               2'b10:   outst_q <= outst_q + 4'd1;
               2'b01:   outst_q <= outst_q - 4'd1;
               default: outst_q <= outst_q;
            endcase
         end

         if (start_acc) completed_q <= '0;
         else if (done_acc && (completed_q != '1)) completed_q <= completed_q + 24'd1;

         // Any start pulse that is not accepted counts as an overrun
         if (start_acc)        overrun_q <= 1'b0;
         else if (frame_start) overrun_q <= 1'b1;

         // A spurious completion in the same cycle as a start still flags
         if (spurious_evt)   spurious_q <= 1'b1;
         else if (start_acc) spurious_q <= 1'b0;
      end
   end

   assign req_vertex_addr = vtx_q;
   assign req_color_addr  = col_q;
   assign req_index       = idx_q;
   assign global_state    = {completed_q, 2'b00, state_q, spurious_q, overrun_q, irq, busy};

`ifdef FRAME_SEQUENCER_PERF_EN
   logic [31:0] cycles_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              cycles_q <= '0;
      else if (start_acc)                     cycles_q <= '0;
      else if (busy && (cycles_q != '1))      cycles_q <= cycles_q + 32'd1;
   end

   assign frame_cycles = cycles_q;
`else
   assign frame_cycles = 32'd0;
`endif

endmodule
